// File: rtl/stream_word_splitter_if.sv
// ============================================================================
// Module   : stream_word_splitter_if
// Brief    : Handshake bundle for the 32-to-16 FWFT word splitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_word_splitter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ENABLE;
    logic                 FIFO_READ_NEXT_OUT;
    logic                 FIFO_EMPTY_IN;
    logic [31:0]          FIFO_DATA_IN;
    logic                 FIFO_READ_NEXT_IN;
    logic                 FIFO_EMPTY_OUT;
    logic [15:0]          FIFO_DATA_OUT;
    logic [CNT_WIDTH-1:0] WORD_COUNT;
    logic                 BUSY;

    // master: the surrounding system (upstream FIFO, downstream core, control)
    modport master (
        output ENABLE, FIFO_EMPTY_IN, FIFO_DATA_IN, FIFO_READ_NEXT_IN,
        input  FIFO_READ_NEXT_OUT, FIFO_EMPTY_OUT, FIFO_DATA_OUT, WORD_COUNT, BUSY
    );

    // slave: the splitter itself
    modport slave (
        input  ENABLE, FIFO_EMPTY_IN, FIFO_DATA_IN, FIFO_READ_NEXT_IN,
        output FIFO_READ_NEXT_OUT, FIFO_EMPTY_OUT, FIFO_DATA_OUT, WORD_COUNT, BUSY
    );
endinterface

`default_nettype wire

// File: rtl/stream_word_splitter.sv
// ============================================================================
// Module   : stream_word_splitter
// Brief    : Pops 32-bit words from an FWFT FIFO, re-presents them as an FWFT
//            16-bit halfword source, one halfword per cycle without bubbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_word_splitter #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST_N,
    stream_word_splitter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_hold;
    logic [CNT_WIDTH-1:0] r_count;
    logic [15:0]          r_data;
    logic                 r_empty;
    logic                 r_busy;
    logic                 w_load;

    function automatic logic [15:0] first_half(input logic [31:0] word);
        return LSB_FIRST ? word[15:0] : word[31:16];
    endfunction

    function automatic logic [15:0] second_half(input logic [31:0] word);
        return LSB_FIRST ? word[31:16] : word[15:0];
    endfunction

    // Gated by reset so no upstream pop can leak out while reset is held.
    assign w_load = BUS_RST_N & bus.ENABLE & ~bus.FIFO_EMPTY_IN &
                    ((r_state == S_EMPTY) |
                     ((r_state == S_SECOND) & bus.FIFO_READ_NEXT_IN));

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_state <= S_EMPTY;
            r_hold  <= 32'h0;
            r_count <= '0;
            r_data  <= 16'h0;
            r_empty <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_load) begin
                        r_state <= S_FIRST;
                        r_hold  <= bus.FIFO_DATA_IN;
                        r_count <= r_count + 1'b1;
                        r_data  <= first_half(bus.FIFO_DATA_IN);
                        r_empty <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FIRST: begin
                    if (bus.FIFO_READ_NEXT_IN) begin
                        r_state <= S_SECOND;
                        r_data  <= second_half(r_hold);
                    end
                end
                S_SECOND: begin
                    // Back-to-back reload keeps the halfword stream bubble-free.
                    if (bus.FIFO_READ_NEXT_IN) begin
                        if (w_load) begin
                            r_state <= S_FIRST;
                            r_hold  <= bus.FIFO_DATA_IN;
                            r_count <= r_count + 1'b1;
                            r_data  <= first_half(bus.FIFO_DATA_IN);
                        end else begin
                            r_state <= S_EMPTY;
                            r_data  <= 16'h0;
                            r_empty <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_data  <= 16'h0;
                    r_empty <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.FIFO_READ_NEXT_OUT = w_load;
    assign bus.FIFO_EMPTY_OUT     = r_empty;
    assign bus.FIFO_DATA_OUT      = r_data;
    assign bus.WORD_COUNT         = r_count;
    assign bus.BUSY               = r_busy;

endmodule

`default_nettype wire
